byte_lane_arbiter: RTL and testbench

BYTE_LANE_ARBITER -- requirements
Module: byte_lane_arbiter

---
 rtl/arb_pkg.sv | 21 ++
 rtl/byte_lane_arbiter_if.sv | 27 ++
 rtl/rr_picker.sv | 24 ++
 rtl/byte_lane_arbiter.sv | 120 ++++++++++++
 tb/tb_byte_lane_arbiter.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/arb_pkg.sv
// Shared types and sizing for the byte-lane arbiter.
package arb_pkg;

  localparam int unsigned NUM_REQ    = 4;
  localparam int unsigned WORD_BEATS = 4;
  localparam int unsigned LANE_W     = 2;
  localparam int unsigned BEAT_W     = 2;
  localparam int unsigned DATA_W     = 8;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  // One byte handed to the packer, tagged with its owning requester.
  typedef struct packed {
    logic [LANE_W-1:0] lane;
    logic [DATA_W-1:0] data;
  } beat_t;

endpackage

// File: rtl/byte_lane_arbiter_if.sv
// Requester-side and packer-side signals of the byte-lane arbiter.
interface byte_lane_arbiter_if;
  import arb_pkg::*;

  logic [NUM_REQ-1:0] req;
  logic [DATA_W-1:0]  data_in0;
  logic [DATA_W-1:0]  data_in1;
  logic [DATA_W-1:0]  data_in2;
  logic [DATA_W-1:0]  data_in3;
  logic               stop;
  logic [NUM_REQ-1:0] pop;
  logic [DATA_W-1:0]  data_out;
  logic               valid_out;
  logic [LANE_W-1:0]  lane_id;
  logic               err;

  modport master (
    output req, data_in0, data_in1, data_in2, data_in3, stop,
    input  pop, data_out, valid_out, lane_id, err
  );

  modport slave (
    input  req, data_in0, data_in1, data_in2, data_in3, stop,
    output pop, data_out, valid_out, lane_id, err
  );

endinterface

// File: rtl/rr_picker.sv
// Round-robin chooser: first requesting index after last, wrapping to last itself.
module rr_picker
  import arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [LANE_W-1:0]  last,
  output logic               any,
  output logic [LANE_W-1:0]  idx
);

  logic [LANE_W-1:0] cand;

  // Scan farthest offset first so the nearest requester after last wins.
  always_comb begin
    any  = |req;
    idx  = last;
    cand = '0;
    for (int k = NUM_REQ; k > 0; k--) begin
      cand = last + LANE_W'(k);
      if (req[cand]) idx = cand;
    end
  end

endmodule

// File: rtl/byte_lane_arbiter.sv
// Grants whole 4-byte words round-robin to byte requesters and streams them to the packer.
module byte_lane_arbiter
  import arb_pkg::*;
(
  input logic                clk_4f,
  input logic                reset_L,
  byte_lane_arbiter_if.slave bus
);

  localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(WORD_BEATS - 1);
  localparam logic [LANE_W-1:0] RESET_LAST = LANE_W'(NUM_REQ - 1);

  arb_state_e         state_q, state_d;
  logic [BEAT_W-1:0]  beat_q, beat_d;
  logic [LANE_W-1:0]  grant_q, grant_d;
  logic [LANE_W-1:0]  last_q, last_d;
  beat_t              out_q, out_d;
  logic               valid_q, valid_d;
  logic               err_q, err_d;
  logic [LANE_W-1:0]  pick_last, pick_idx;
  logic               pick_any;
  logic [DATA_W-1:0]  head_byte;
  logic [NUM_REQ-1:0] pop_c;

  // At a word boundary the current grant acts as the round-robin reference.
  assign pick_last = (state_q == BURST) ? grant_q : last_q;

  rr_picker u_picker (
    .req  (bus.req),
    .last (pick_last),
    .any  (pick_any),
    .idx  (pick_idx)
  );

  always_comb begin
    head_byte = bus.data_in0;
    case (grant_q)
      2'd1:    head_byte = bus.data_in1;
      2'd2:    head_byte = bus.data_in2;
      2'd3:    head_byte = bus.data_in3;
      default: head_byte = bus.data_in0;
    endcase
  end

  always_ff @(posedge clk_4f or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= IDLE;
      beat_q  <= '0;
      grant_q <= '0;
      last_q  <= RESET_LAST;
      out_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    grant_d = grant_q;
    last_d  = last_q;
    out_d   = out_q;
    valid_d = 1'b0;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (!bus.stop && pick_any) begin
          grant_d = pick_idx;
          beat_d  = '0;
          state_d = BURST;
        end
      end
      BURST: begin
        if (bus.req[grant_q]) begin
          valid_d    = 1'b1;
          out_d.data = head_byte;
          out_d.lane = grant_q;
          if (beat_q == LAST_BEAT) begin
            last_d = grant_q;
            // Back-to-back words when allowed, otherwise drop to IDLE.
            if (!bus.stop && pick_any) begin
              grant_d = pick_idx;
              beat_d  = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end else begin
          // Requester vanished mid-word: flag it and let the bubble realign the packer.
          err_d   = 1'b1;
          last_d  = grant_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pop_c = '0;
    if (state_q == BURST && bus.req[grant_q]) pop_c[grant_q] = 1'b1;
  end

  assign bus.pop       = pop_c;
  assign bus.data_out  = out_q.data;
  assign bus.lane_id   = out_q.lane;
  assign bus.valid_out = valid_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_byte_lane_arbiter.sv
// Scoreboard bench for byte_lane_arbiter: per-lane byte sources, expected beats queued ahead.
module tb_byte_lane_arbiter;

  typedef struct packed {
    logic [1:0] lane;
    logic [7:0] data;
  } exp_beat_t;

  logic clk_4f;
  logic reset_L;

  byte_lane_arbiter_if bus ();

  byte_lane_arbiter u_dut (
    .clk_4f  (clk_4f),
    .reset_L (reset_L),
    .bus     (bus)
  );

  int        errors;
  int        checks;
  int        ptr [4];
  int        exp_idx [4];
  int        cyc;
  int        nbeats;
  int        beat_cyc [64];
  exp_beat_t sb [$];
  exp_beat_t mon_e;

  initial clk_4f = 1'b0;
  always #5 clk_4f = ~clk_4f;

  // Byte k of lane i; lane 0 opens with 11,22,33,44.
  function automatic logic [7:0] byte_of(int lane, int k);
    if (lane == 0 && k < 4) return 8'(8'h11 * (k + 1));
    return {4'(lane + 1), 4'(k)};
  endfunction

  assign bus.data_in0 = byte_of(0, ptr[0]);
  assign bus.data_in1 = byte_of(1, ptr[1]);
  assign bus.data_in2 = byte_of(2, ptr[2]);
  assign bus.data_in3 = byte_of(3, ptr[3]);

  // Show-ahead FIFO heads advance on each pop.
  always @(posedge clk_4f) begin
    for (int i = 0; i < 4; i++) if (bus.pop[i]) ptr[i] <= ptr[i] + 1;
  end

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Compare every valid beat against the head of the scoreboard.
  always @(negedge clk_4f) begin
    cyc++;
    if (bus.valid_out) begin
      if (sb.size() == 0) begin
        check("extra_beat", 32'(bus.valid_out), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("lane_id", 32'(bus.lane_id), 32'(mon_e.lane));
        check("data_out", 32'(bus.data_out), 32'(mon_e.data));
      end
      if (nbeats < 64) beat_cyc[nbeats] = cyc;
      nbeats++;
    end
  end

  task automatic tick();
    @(negedge clk_4f);
    #1;
  endtask

  task automatic push_word(int lane, int n);
    for (int i = 0; i < n; i++) begin
      sb.push_back('{lane: 2'(lane), data: byte_of(lane, exp_idx[lane])});
      exp_idx[lane]++;
    end
  endtask

  task automatic wait_beats(int n, int budget);
    int c = 0;
    while (nbeats < n && c < budget) begin
      tick();
      c++;
    end
    if (nbeats < n) check("beat_timeout", 32'(nbeats), 32'(n));
  endtask

  task automatic do_reset();
    reset_L = 1'b0;
    tick();
    tick();
    check("rst_valid", 32'(bus.valid_out), 32'd0);
    check("rst_pop", 32'(bus.pop), 32'd0);
    check("rst_data", 32'(bus.data_out), 32'd0);
    check("rst_lane", 32'(bus.lane_id), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    reset_L = 1'b1;
    nbeats  = 0;
  endtask

  initial begin
    errors   = 0;
    checks   = 0;
    nbeats   = 0;
    reset_L  = 1'b0;
    bus.req  = 4'b0000;
    bus.stop = 1'b0;
    tick();

    // Single requester: one word, one-cycle pop-to-valid latency.
    do_reset();
    push_word(0, 4);
    bus.req = 4'b0001;
    tick();
    check("t1_pop_first", 32'(bus.pop), 32'd1);
    check("t1_valid_lat", 32'(bus.valid_out), 32'd0);
    wait_beats(1, 10);
    bus.stop = 1'b1;
    wait_beats(4, 10);
    repeat (4) tick();
    check("t1_pop_idle", 32'(bus.pop), 32'd0);
    check("t1_ptr0", 32'(ptr[0]), 32'd4);
    check("t1_beats", 32'(nbeats), 32'd4);
    check("t1_contig", 32'(beat_cyc[3] - beat_cyc[0]), 32'd3);
    check("t1_sb_empty", 32'(sb.size()), 32'd0);
    bus.req  = 4'b0000;
    bus.stop = 1'b0;

    // Fairness: all requesting, word order 0,1,2,3,0 without bubbles.
    do_reset();
    push_word(0, 4);
    push_word(1, 4);
    push_word(2, 4);
    push_word(3, 4);
    push_word(0, 4);
    bus.req = 4'b1111;
    wait_beats(17, 40);
    bus.stop = 1'b1;
    wait_beats(20, 20);
    repeat (4) tick();
    check("t2_beats", 32'(nbeats), 32'd20);
    check("t2_no_bubble", 32'(beat_cyc[19] - beat_cyc[0]), 32'd19);
    check("t2_pop_idle", 32'(bus.pop), 32'd0);
    check("t2_sb_empty", 32'(sb.size()), 32'd0);
    bus.req  = 4'b0000;
    bus.stop = 1'b0;

    // Backpressure mid-word on lane 2, then lane 3 once released.
    do_reset();
    bus.req = 4'b1100;
    push_word(2, 4);
    wait_beats(1, 10);
    bus.stop = 1'b1;
    wait_beats(4, 10);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t3_pop_held", 32'(bus.pop), 32'd0);
    end
    check("t3_beats_held", 32'(nbeats), 32'd4);
    push_word(3, 4);
    bus.stop = 1'b0;
    wait_beats(5, 10);
    bus.stop = 1'b1;
    wait_beats(8, 10);
    repeat (3) tick();
    check("t3_beats", 32'(nbeats), 32'd8);
    check("t3_lane", 32'(bus.lane_id), 32'd3);
    check("t3_sb_empty", 32'(sb.size()), 32'd0);
    bus.req  = 4'b0000;
    bus.stop = 1'b0;

    // Abort: lane 1 drops req at beat 2, lane 2 takes over.
    do_reset();
    bus.req = 4'b0010;
    push_word(1, 2);
    push_word(2, 4);
    wait_beats(2, 10);
    check("t4_err_pre", 32'(bus.err), 32'd0);
    bus.req = 4'b0100;
    tick();
    check("t4_err_set", 32'(bus.err), 32'd1);
    check("t4_bubble", 32'(bus.valid_out), 32'd0);
    wait_beats(3, 10);
    bus.stop = 1'b1;
    wait_beats(6, 10);
    repeat (3) tick();
    check("t4_gap", 32'(beat_cyc[2] - beat_cyc[1] >= 2), 32'd1);
    check("t4_err_sticky", 32'(bus.err), 32'd1);
    check("t4_sb_empty", 32'(sb.size()), 32'd0);

    // Reset mid-word discards the word; lane 3 wins afterwards.
    nbeats   = 0;
    bus.stop = 1'b0;
    bus.req  = 4'b0001;
    push_word(0, 1);
    wait_beats(1, 10);
    reset_L = 1'b0;
    #1;
    check("t5_valid_rst", 32'(bus.valid_out), 32'd0);
    check("t5_pop_rst", 32'(bus.pop), 32'd0);
    check("t5_err_rst", 32'(bus.err), 32'd0);
    tick();
    tick();
    check("t5_pop_held", 32'(bus.pop), 32'd0);
    bus.req = 4'b1000;
    push_word(3, 4);
    reset_L = 1'b1;
    wait_beats(3, 10);
    bus.stop = 1'b1;
    wait_beats(5, 10);
    repeat (3) tick();
    check("t5_beats", 32'(nbeats), 32'd5);
    check("t5_lane", 32'(bus.lane_id), 32'd3);
    check("t5_sb_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
